// File: rtl/ram_2port.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// Read-during-write to the same address returns the pre-write contents.
module ram_2port #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] wraddress,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Contents start at zero from configuration; reset deliberately leaves them alone.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  // Write port: suppressed while reset is held.
  always_ff @(posedge clock) begin
    if (reset_n && wren) begin
      mem[wraddress] <= data;
    end
  end

  // Read port: non-blocking read of mem yields old data on a same-address write.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q <= '0;
    end else if (rden) begin
      q <= mem[rdaddress];
    end else begin
      q <= q;
    end
  end

endmodule

// File: tb/tb_ram_2port.sv
// Self-checking bench for ram_2port: associative-array memory model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_ram_2port;

  logic        clock;
  logic        reset_n;
  logic [7:0]  data;
  logic [13:0] wraddress;
  logic        wren;
  logic [13:0] rdaddress;
  logic        rden;
  logic [7:0]  q;

  int checks;
  int errors;

  logic [7:0] mm [int];
  logic [7:0] exp_q;
  logic       started;

  ram_2port #(.DATA_WIDTH(8), .ADDR_WIDTH(14)) dut (
    .clock(clock), .reset_n(reset_n), .data(data), .wraddress(wraddress),
    .wren(wren), .rdaddress(rdaddress), .rden(rden), .q(q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] rd_model(input int a);
    return mm.exists(a) ? mm[a] : 8'h00;
  endfunction

  // Model: reset forces q to zero and drops writes; reads see contents before this edge's write.
  always @(posedge clock) begin
    if (!reset_n) begin
      exp_q = 8'h00;
    end else begin
      if (rden) exp_q = rd_model(int'(rdaddress));
      if (wren) mm[int'(wraddress)] = data;
    end
    started = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (started) check("model_q", q, exp_q);
  end

  task automatic step(input logic rn, input logic we, input logic [13:0] wa,
                      input logic [7:0] d, input logic re, input logic [13:0] ra);
    reset_n   = rn;
    wren      = we;
    wraddress = wa;
    data      = d;
    rden      = re;
    rdaddress = ra;
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; started = 1'b0; exp_q = 8'h00;
    reset_n = 1'b0; wren = 1'b0; rden = 1'b0;
    data = 8'h00; wraddress = 14'h0000; rdaddress = 14'h0000;
    #2;

    // Reset for two cycles, then power-up zero read
    step(1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 14'h0000);
    step(1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 14'h0000);
    check("reset_q", q, 8'h00);
    step(1'b1, 1'b0, 14'h0000, 8'h00, 1'b1, 14'h0005);
    check("powerup_zero", q, 8'h00);

    // Basic write then read, then hold with rden low
    step(1'b1, 1'b1, 14'h0010, 8'hA5, 1'b0, 14'h0000);
    step(1'b1, 1'b0, 14'h0000, 8'h00, 1'b1, 14'h0010);
    check("read_a5", q, 8'hA5);
    step(1'b1, 1'b1, 14'h0010, 8'hFF, 1'b0, 14'h0010);
    step(1'b1, 1'b0, 14'h0000, 8'h00, 1'b0, 14'h0000);
    check("hold_a5", q, 8'hA5);

    // Read-during-write, same address
    step(1'b1, 1'b1, 14'h0020, 8'h11, 1'b0, 14'h0000);
    step(1'b1, 1'b1, 14'h0020, 8'h3C, 1'b1, 14'h0020);
    check("rdw_old", q, 8'h11);
    step(1'b1, 1'b0, 14'h0000, 8'h00, 1'b1, 14'h0020);
    check("rdw_new", q, 8'h3C);

    // Address boundaries and independent ports
    step(1'b1, 1'b1, 14'h0000, 8'h01, 1'b0, 14'h0000);
    step(1'b1, 1'b1, 14'h3FFF, 8'hFE, 1'b0, 14'h0000);
    step(1'b1, 1'b1, 14'h0001, 8'h77, 1'b1, 14'h0000);
    check("bound_lo", q, 8'h01);
    step(1'b1, 1'b0, 14'h0000, 8'h00, 1'b1, 14'h3FFF);
    check("bound_hi", q, 8'hFE);
    step(1'b1, 1'b0, 14'h0000, 8'h00, 1'b1, 14'h0001);
    check("indep_wr", q, 8'h77);

    // Reset mid-operation: write dropped, contents retained
    step(1'b1, 1'b1, 14'h0100, 8'h5A, 1'b0, 14'h0000);
    step(1'b0, 1'b1, 14'h0100, 8'h99, 1'b1, 14'h0100);
    check("rst_mid_q", q, 8'h00);
    step(1'b1, 1'b0, 14'h0000, 8'h00, 1'b1, 14'h0100);
    check("rst_retain", q, 8'h5A);

    // Sequential fill of 1000 words, then streaming readback
    for (int i = 0; i < 1000; i++) begin
      logic [13:0] a;
      logic [7:0]  dv;
      a  = 14'h0200 + 14'(i);
      dv = 8'(i * 7 + 3) ^ 8'(i >> 8);
      step(1'b1, 1'b1, a, dv, 1'b0, 14'h0000);
    end
    for (int i = 0; i < 1000; i++) begin
      logic [13:0] a;
      logic [7:0]  dv;
      a  = 14'h0200 + 14'(i);
      dv = 8'(i * 7 + 3) ^ 8'(i >> 8);
      step(1'b1, 1'b0, 14'h0000, 8'h00, 1'b1, a);
      check("seq_read", q, dv);
    end
    step(1'b1, 1'b0, 14'h0000, 8'h00, 1'b0, 14'h0000);
    step(1'b1, 1'b0, 14'h0000, 8'h00, 1'b0, 14'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_2port.md
RAM_2PORT -- requirements
Module: ram_2port

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 14, address width in bits; DEPTH = 2**ADDR_WIDTH words (16384 by default).
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 data  input  DATA_WIDTH  write data.
REQ-006 wraddress  input  ADDR_WIDTH  write address.
REQ-007 wren  input  1  write enable, active-high.
REQ-008 rdaddress  input  ADDR_WIDTH  read address.
REQ-009 rden  input  1  read enable, active-high.
REQ-010 q  output  DATA_WIDTH  registered read data.

Function
REQ-011 The block SHALL be a simple dual-port memory: one write port and one independent read port, both clocked by clock.
REQ-012 Write: on a rising edge with reset_n=1 and wren=1, mem[wraddress] SHALL take the value of data.
REQ-013 Write enable low: mem SHALL be unchanged.
REQ-014 Read: on a rising edge with reset_n=1 and rden=1, q SHALL take mem[rdaddress]; read latency is exactly 1 cycle from address/rden sampling to q valid.
REQ-015 rden=0: q SHALL hold its previous value.
REQ-016 Read-during-write, same address, same edge: q SHALL return the old (pre-write) contents; the new value SHALL be readable from the next read onward.
REQ-017 Read and write to different addresses on the same edge SHALL be fully independent.
REQ-018 Addresses SHALL use the full ADDR_WIDTH range; no out-of-range case exists, and there is no wrap logic inside the block.
REQ-019 Memory contents SHALL initialise to all zeros at power-up/configuration.
REQ-020 The block SHALL contain no combinational path from any input to q.

Reset
REQ-021 On a rising edge with reset_n=0, q SHALL become 0.
REQ-022 While reset_n=0, writes SHALL be suppressed; wren is ignored and mem is unchanged.
REQ-023 While reset_n=0, reads SHALL be suppressed.
REQ-024 Reset SHALL NOT clear memory contents; data written before reset SHALL remain readable after reset_n returns to 1.
REQ-025 Reset asserted mid-operation SHALL take effect at the same edge, including a cycle where wren=1 or rden=1; that write is lost and q reads 0.
REQ-026 The first read after reset_n deasserts SHALL behave per REQ-014 with no extra latency.

Verification
REQ-027 Reset with reset_n=0 for 2 cycles -> q=0x00; then read address 0x0005 with rden=1 -> q=0x00 one cycle later (power-up zero).
REQ-028 Write 0xA5 to 0x0010, then read 0x0010 on the next cycle -> q=0xA5 exactly 1 cycle after the read edge; with rden=0 afterwards, q stays 0xA5.
REQ-029 Write 0x3C to 0x0020 while 0x0020 holds 0x11, reading 0x0020 on the same edge -> q=0x11; read again the next cycle -> q=0x3C.
REQ-030 Fill addresses 0x0000 and 0x3FFF with 0x01 and 0xFE, and write 0x77 to 0x0001 while reading 0x0000 on the same edge -> reads return 0x01, 0xFE, 0x77 respectively (boundaries and independent ports).
REQ-031 Write 0x5A to 0x0100, assert reset_n=0 on an edge with wren=1 and data=0x99 to 0x0100, release reset, read 0x0100 -> q=0x00 during reset, then q=0x5A (contents retained, write during reset dropped).
REQ-032 Write 1000 sequential addresses with address-derived data, then read them back in order with rden held high -> each q matches, 1-cycle latency, no gaps.
